// File: rtl/tsu_rx_latency_extract_pkg.sv
// Shared constants, FSM state and record type for the RX latency extractor.
package tsu_pkg;

    localparam logic [5:0] OFF_ETYPE       = 6'd12;
    localparam logic [5:0] OFF_SEQ         = 6'd16;
    localparam logic [5:0] OFF_TXTS        = 6'd20;
    localparam logic [5:0] OFF_RXTS        = 6'd28;
    localparam logic [5:0] LAST_FIELD_BYTE = 6'd35;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        BODY,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [31:0] seq;
        logic [63:0] latency;
    } rec_t;

endpackage

// File: rtl/tsu_rx_latency_extract_if.sv
// Stamped byte stream in, latency record stream out.
interface tsu_rx_latency_extract_if;

    logic        mac_axis_tvalid;
    logic        mac_axis_tready;
    logic [7:0]  mac_axis_tdata;
    logic        mac_axis_tlast;
    logic        lat_tvalid;
    logic        lat_tready;
    logic [31:0] lat_seq;
    logic [63:0] lat_value;

    modport master (
        output mac_axis_tvalid, mac_axis_tready, mac_axis_tdata, mac_axis_tlast,
        output lat_tready,
        input  lat_tvalid, lat_seq, lat_value
    );

    modport slave (
        input  mac_axis_tvalid, mac_axis_tready, mac_axis_tdata, mac_axis_tlast,
        input  lat_tready,
        output lat_tvalid, lat_seq, lat_value
    );

endinterface

// File: rtl/tsu_lat_fifo.sv
// Show-ahead record FIFO; a push at full is accepted when a pop happens in the same cycle.
module tsu_lat_fifo
    import tsu_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  rec_t din,
    input  logic pop,
    output rec_t dout,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    rec_t           mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    always_comb begin
        empty   = (count == '0);
        full    = (count == (AW+1)'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        dout    = empty ? '0 : mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tsu_rx_latency_extract.sv
// Pulls seq/TX/RX timestamps out of critical frames and queues {seq, RX-TX} records.
module tsu_rx_latency_extract
    import tsu_pkg::*;
#(
    parameter logic [15:0] CRITICAL_ETHERTYPE = 16'h88B5,
    parameter int unsigned FIFO_DEPTH         = 8,
    parameter int unsigned CNT_W              = 16
) (
    input  logic                  mac_axis_aclk,
    input  logic                  rst,
    tsu_rx_latency_extract_if.slave bus,
    output logic [CNT_W-1:0]      frame_cnt,
    output logic [CNT_W-1:0]      short_cnt,
    output logic [CNT_W-1:0]      drop_cnt
);

    state_t      state, state_nx;
    logic [5:0]  bcnt;
    logic [7:0]  etype_hi;
    logic [31:0] seq_q, seq_nx;
    logic [63:0] tx_q, tx_nx;
    logic [63:0] rx_q, rx_nx;
    logic        critical, fields_ok;
    logic        beat, is_last, at_etype_lo, crit_now, crit_eff, fok_eff;
    logic        cap_etype, cap_seq, cap_tx, cap_rx, last_field;
    logic        commit_ok, commit_short;
    logic        pipe_valid;
    rec_t        pipe_rec, head;
    logic        fifo_full, fifo_empty, lat_pop, drop;

    always_ff @(posedge mac_axis_aclk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (beat) begin
            if (bus.mac_axis_tlast) begin
                state_nx = IDLE;
            end else begin
                case (state)
                    IDLE:    state_nx = HDR;
                    HDR:     if (at_etype_lo) state_nx = crit_now ? BODY : DRAIN;
                    default: state_nx = state;
                endcase
            end
        end
    end

    // Commit-cycle flags fold in the current beat so tlast on byte 13 or byte 35 is judged correctly.
    always_comb begin
        beat        = bus.mac_axis_tvalid && bus.mac_axis_tready;
        is_last     = beat && bus.mac_axis_tlast;
        cap_etype   = beat && (state == HDR) && (bcnt == OFF_ETYPE);
        at_etype_lo = beat && (state == HDR) && (bcnt == OFF_ETYPE + 6'd1);
        crit_now    = ({etype_hi, bus.mac_axis_tdata} == CRITICAL_ETHERTYPE);
        cap_seq     = beat && (state == BODY) && (bcnt >= OFF_SEQ)  && (bcnt < OFF_TXTS);
        cap_tx      = beat && (state == BODY) && (bcnt >= OFF_TXTS) && (bcnt < OFF_RXTS);
        cap_rx      = beat && (state == BODY) && (bcnt >= OFF_RXTS) && (bcnt <= LAST_FIELD_BYTE);
        last_field  = beat && (state == BODY) && (bcnt == LAST_FIELD_BYTE);
        seq_nx      = cap_seq ? {seq_q[23:0], bus.mac_axis_tdata} : seq_q;
        tx_nx       = cap_tx  ? {tx_q[55:0],  bus.mac_axis_tdata} : tx_q;
        rx_nx       = cap_rx  ? {rx_q[55:0],  bus.mac_axis_tdata} : rx_q;
        crit_eff    = at_etype_lo ? crit_now : critical;
        fok_eff     = fields_ok || last_field;
        commit_ok   = is_last && crit_eff && fok_eff;
        commit_short = is_last && crit_eff && !fok_eff;
        lat_pop     = !fifo_empty && bus.lat_tready;
        drop        = pipe_valid && fifo_full && !lat_pop;
    end

    always_ff @(posedge mac_axis_aclk) begin
        if (rst) begin
            bcnt       <= '0;
            etype_hi   <= '0;
            seq_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            critical   <= 1'b0;
            fields_ok  <= 1'b0;
            pipe_valid <= 1'b0;
            pipe_rec   <= '0;
        end else begin
            if (beat) begin
                if (bus.mac_axis_tlast)  bcnt <= '0;
                else if (bcnt != '1)     bcnt <= bcnt + 1'b1;
            end
            if (cap_etype) etype_hi <= bus.mac_axis_tdata;
            seq_q <= seq_nx;
            tx_q  <= tx_nx;
            rx_q  <= rx_nx;
            if (is_last) begin
                critical  <= 1'b0;
                fields_ok <= 1'b0;
            end else begin
                if (at_etype_lo) critical  <= crit_now;
                if (last_field)  fields_ok <= 1'b1;
            end
            pipe_valid <= commit_ok;
            if (commit_ok) pipe_rec <= '{seq: seq_nx, latency: rx_nx - tx_nx};
        end
    end

    always_ff @(posedge mac_axis_aclk) begin
        if (rst) begin
            frame_cnt <= '0;
            short_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (pipe_valid && !drop && frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
            if (drop && drop_cnt != '1)                 drop_cnt  <= drop_cnt + 1'b1;
            if (commit_short && short_cnt != '1)        short_cnt <= short_cnt + 1'b1;
        end
    end

    tsu_lat_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (mac_axis_aclk),
        .rst   (rst),
        .push  (pipe_valid),
        .din   (pipe_rec),
        .pop   (lat_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.lat_tvalid = !fifo_empty;
    assign bus.lat_seq    = head.seq;
    assign bus.lat_value  = head.latency;

endmodule

// File: tb/tb_tsu_rx_latency_extract.sv
// Directed frames with a record scoreboard and counter checks for tsu_rx_latency_extract.
module tb_tsu_rx_latency_extract;
    import tsu_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] frame_cnt, short_cnt, drop_cnt;
    rec_t        exp_q[$];
    rec_t        exp_rec;
    int          checks = 0;
    int          errors = 0;

    tsu_rx_latency_extract_if bus();

    tsu_rx_latency_extract #(
        .CRITICAL_ETHERTYPE (16'h88B5),
        .FIFO_DEPTH         (8),
        .CNT_W              (16)
    ) dut (
        .mac_axis_aclk (clk),
        .rst           (rst),
        .bus           (bus),
        .frame_cnt     (frame_cnt),
        .short_cnt     (short_cnt),
        .drop_cnt      (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.lat_tvalid && bus.lat_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_record: got seq %0h lat %0h expected none",
                         bus.lat_seq, bus.lat_value);
            end else begin
                exp_rec = exp_q.pop_front();
                chk("rec_seq", 64'(bus.lat_seq), 64'(exp_rec.seq));
                chk("rec_lat", bus.lat_value, exp_rec.latency);
            end
        end
    end

    function automatic logic [7:0] fbyte(input int i, input logic [31:0] s,
                                         input logic [63:0] t, input logic [63:0] r,
                                         input logic [15:0] e);
        logic [7:0] b;
        b = 8'(i);
        if (i == 12)                 b = e[15:8];
        else if (i == 13)            b = e[7:0];
        else if (i >= 16 && i <= 19) b = s[8*(19-i) +: 8];
        else if (i >= 20 && i <= 27) b = t[8*(27-i) +: 8];
        else if (i >= 28 && i <= 35) b = r[8*(35-i) +: 8];
        return b;
    endfunction

    task automatic send_frame(input logic [31:0] s, input logic [63:0] t, input logic [63:0] r,
                              input logic [15:0] e, input int len, input bit gaps, input int rst_at);
        for (int i = 0; i < len; i++) begin
            if (gaps && (i % 7 == 3)) begin
                bus.mac_axis_tvalid = 1'b1;
                bus.mac_axis_tready = 1'b0;
                bus.mac_axis_tdata  = 8'hEE;
                bus.mac_axis_tlast  = 1'b1;
                @(posedge clk); #1;
                bus.mac_axis_tvalid = 1'b0;
                bus.mac_axis_tready = 1'b1;
                @(posedge clk); #1;
            end
            bus.mac_axis_tvalid = 1'b1;
            bus.mac_axis_tready = 1'b1;
            bus.mac_axis_tdata  = fbyte(i, s, t, r, e);
            bus.mac_axis_tlast  = (i == len - 1);
            rst = (i == rst_at);
            @(posedge clk); #1;
            rst = 1'b0;
        end
        bus.mac_axis_tvalid = 1'b0;
        bus.mac_axis_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_cnts(input string tag, input int f, input int s, input int d);
        chk({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(f));
        chk({tag, "_short_cnt"}, 64'(short_cnt), 64'(s));
        chk({tag, "_drop_cnt"},  64'(drop_cnt),  64'(d));
    endtask

    initial begin
        rst                 = 1'b1;
        bus.mac_axis_tvalid = 1'b0;
        bus.mac_axis_tready = 1'b1;
        bus.mac_axis_tdata  = '0;
        bus.mac_axis_tlast  = 1'b0;
        bus.lat_tready      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_tvalid", 64'(bus.lat_tvalid), 64'd0);
        chk("rst_seq", 64'(bus.lat_seq), 64'd0);
        chk("rst_value", bus.lat_value, 64'd0);
        chk_cnts("rst", 0, 0, 0);

        // Single critical 64-byte frame, record must show within two cycles of tlast.
        exp_q.push_back('{seq: 32'h0000_0007, latency: 64'd250});
        send_frame(32'h0000_0007, 64'd1000, 64'd1250, 16'h88B5, 64, 1'b0, -1);
        repeat (2) @(posedge clk);
        #1;
        chk("tlast_plus2_tvalid", 64'(bus.lat_tvalid), 64'd1);
        bus.lat_tready = 1'b1;
        wait_drain();
        chk_cnts("single", 1, 0, 0);

        // Non-critical EtherType with valid-looking fields.
        send_frame(32'h0000_0007, 64'd1000, 64'd1250, 16'h0800, 64, 1'b0, -1);
        repeat (5) @(posedge clk);
        #1;
        chk("noncrit_tvalid", 64'(bus.lat_tvalid), 64'd0);
        chk_cnts("noncrit", 1, 0, 0);

        // Short frame ending at byte 30, then a gappy valid frame.
        send_frame(32'h0000_0009, 64'd1, 64'd2, 16'h88B5, 31, 1'b0, -1);
        repeat (3) @(posedge clk);
        #1;
        chk_cnts("short30", 1, 1, 0);
        exp_q.push_back('{seq: 32'h1234_5678, latency: 64'h1234});
        send_frame(32'h1234_5678, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_1234,
                   16'h88B5, 50, 1'b1, -1);
        wait_drain();
        chk_cnts("gappy", 2, 1, 0);

        // Boundary lengths: tlast on byte 35 is complete, tlast on byte 13 is short.
        exp_q.push_back('{seq: 32'h0000_000A, latency: 64'd20});
        send_frame(32'h0000_000A, 64'd10, 64'd30, 16'h88B5, 36, 1'b0, -1);
        send_frame(32'h0000_000B, 64'd10, 64'd30, 16'h88B5, 14, 1'b0, -1);
        wait_drain();
        chk_cnts("boundary", 3, 2, 0);

        // TX later than RX wraps.
        exp_q.push_back('{seq: 32'h0000_0055, latency: 64'hFFFF_FFFF_FFFF_FF9C});
        send_frame(32'h0000_0055, 64'd500, 64'd400, 16'h88B5, 40, 1'b0, -1);
        wait_drain();
        chk_cnts("wrap", 4, 2, 0);

        // Nine back-to-back frames with the consumer stalled: one drop.
        bus.lat_tready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k < 8) exp_q.push_back('{seq: 32'(100 + k), latency: 64'(k + 1)});
            send_frame(32'(100 + k), 64'(k * 1000), 64'(k * 1000 + k + 1), 16'h88B5, 40, 1'b0, -1);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("full_tvalid", 64'(bus.lat_tvalid), 64'd1);
        chk_cnts("full", 12, 2, 1);

        // Push at full coinciding with the first pop.
        exp_q.push_back('{seq: 32'd200, latency: 64'd5});
        send_frame(32'd200, 64'd10, 64'd15, 16'h88B5, 40, 1'b0, -1);
        bus.lat_tready = 1'b1;
        wait_drain();
        chk_cnts("full_pop", 13, 2, 1);

        // Reset in the middle of a critical frame while its bytes keep flowing.
        send_frame(32'h0000_0077, 64'd1, 64'd99, 16'h88B5, 40, 1'b0, 25);
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_tvalid", 64'(bus.lat_tvalid), 64'd0);
        chk_cnts("midrst", 0, 0, 0);
        exp_q.push_back('{seq: 32'hDEAD_BEEF, latency: 64'h11});
        send_frame(32'hDEAD_BEEF, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7799,
                   16'h88B5, 60, 1'b0, -1);
        wait_drain();
        chk_cnts("post_rst", 1, 0, 0);
        chk("end_tvalid", 64'(bus.lat_tvalid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
